arb8_rr_seq: RTL
================

ARB8_RR_SEQ -- requirements
Module: arb8_rr_seq

Interface
REQ-001 Parameter HOLD_MAX, default 15, maximum consecutive GRANT cycles before forced release; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 en  input  1  arbitration enable; low blocks new grants.
REQ-005 req  input  8  request lines, bit i = requester i, level-sensitive.
REQ-006 done  input  1  current owner releases grant.
REQ-007 gnt  output  8  one-hot grant, registered.
REQ-008 gidx  output  3  binary index of granted requester, registered.
REQ-009 gvalid  output  1  high while a grant is held, registered.
REQ-010 tmo  output  1  one-cycle pulse on forced release.
REQ-011 seg  output  7  active-low 7-segment display of gidx, seg[0]=a .. seg[6]=g.

Function
REQ-012 State machine SHALL have three states: IDLE, GRANT, GAP.
REQ-013 IDLE: if en=1 and req!=0 at a rising edge, SHALL select the first set req bit searching upward from ptr with wrap 7->0, enter GRANT, set gnt/gidx/gvalid at that same edge (1-cycle latency from sampled req).
REQ-014 IDLE with en=0 or req=0 SHALL remain IDLE with gnt=0, gvalid=0.
REQ-015 GRANT: hold counter cnt (8 bits) SHALL be 1 on the first GRANT cycle and increment each further GRANT cycle.
REQ-016 GRANT exit conditions, sampled each edge, priority order: done=1; req[gidx]=0; cnt==HOLD_MAX. Any one SHALL move to GAP.
REQ-017 On exit to GAP: gnt=0, gvalid=0, cnt=0, ptr=gidx+1 mod 8 (7 wraps to 0); gidx retains last value.
REQ-018 tmo SHALL be 1 for exactly the GAP cycle entered due to cnt==HOLD_MAX with done=1 absent and req[gidx]=1; else 0.
REQ-019 en and other req bits SHALL NOT affect GRANT state.
REQ-020 GAP SHALL last exactly one cycle then enter IDLE unconditionally; minimum release-to-next-grant spacing is 2 edges.
REQ-021 gnt SHALL be one-hot or zero at all times; gnt[gidx]=1 iff gvalid=1.
REQ-022 seg SHALL be combinational from gvalid/gidx: gvalid=0 -> 7'h7F; gidx 0..7 -> 7'h40,7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78.
REQ-023 HOLD_MAX=1 SHALL give exactly one GRANT cycle per grant.

Reset
REQ-024 rst_n low SHALL immediately, without clock, force state=IDLE, ptr=0, cnt=0, gnt=8'h00, gidx=0, gvalid=0, tmo=0, hence seg=7'h7F.
REQ-025 Reset asserted mid-GRANT SHALL drop the grant with no tmo pulse; after release, first arbitration SHALL start from ptr=0.
REQ-026 First edge after rst_n deassertion SHALL be a normal IDLE evaluation.

Verification
REQ-027 Reset, en=1, req=8'h05, done pulsed 1 cycle after each grant -> grants in order idx 0, 2, 0, 2; seg 7'h40, 7'h24 alternating, 7'h7F in gaps.
REQ-028 HOLD_MAX=3, req=8'h80 held, done=0 -> gnt=8'h80 for 3 cycles, tmo=1 one cycle, ptr wraps to 0, regrant idx 7 two edges later.
REQ-029 Grant idx 3 held, then req[3] dropped while req=8'h41 -> GAP, then grant idx 6 (search from 4), not idx 0.
REQ-030 en=0 with req=8'hFF for 10 cycles -> gvalid=0, seg=7'h7F throughout; en=1 -> grant idx 0 next edge.
REQ-031 rst_n pulsed low asynchronously mid-GRANT (idx 5, cnt=2) -> gnt=0, seg=7'h7F before next edge, tmo=0; after release req=8'hFF -> grant idx 0.

Source files
------------

// File: rtl/arb8_rr_seq.sv
// Eight-way round-robin arbiter with hold limit, one-cycle release gap and
// a 7-segment readout of the current grant index.
module arb8_rr_seq #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gidx,
    output logic       gvalid,
    output logic       tmo,
    output logic [6:0] seg
);

    localparam int unsigned NREQ  = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]    gnt_d;
    logic [IDX_W-1:0]   gidx_d;
    logic               gvalid_d;
    logic               tmo_d;

    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   probe;
    logic               hold_hit;

    // First set request at or above ptr, wrapping 7 -> 0.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        probe = ptr_q;
        for (int i = 0; i < int'(NREQ); i++) begin
            probe = ptr_q + IDX_W'(i);
            if (!found && req[probe]) begin
                found = 1'b1;
                pick  = probe;
            end
        end
    end

    assign hold_hit = (cnt_q == CNT_W'(HOLD_MAX));

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt;
        gidx_d   = gidx;
        gvalid_d = gvalid;
        tmo_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_d    = '0;
                gvalid_d = 1'b0;
                if (en && found) begin
                    state_d  = GRANT;
                    gnt_d    = NREQ'(1) << pick;
                    gidx_d   = pick;
                    gvalid_d = 1'b1;
                    cnt_d    = CNT_W'(1);
                end
            end
            GRANT: begin
                if (done || !req[gidx] || hold_hit) begin
                    state_d  = GAP;
                    gnt_d    = '0;
                    gvalid_d = 1'b0;
                    cnt_d    = '0;
                    ptr_d    = gidx + IDX_W'(1);
                    tmo_d    = !done && req[gidx];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gvalid_d = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            gidx    <= '0;
            gvalid  <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            gidx    <= gidx_d;
            gvalid  <= gvalid_d;
            tmo     <= tmo_d;
        end
    end

    // Active-low segments a..g in bits 0..6; blank when nothing is granted.
    always_comb begin
        seg = 7'h7F;
        if (gvalid) begin
            unique case (gidx)
                3'd0: seg = 7'h40;
                3'd1: seg = 7'h79;
                3'd2: seg = 7'h24;
                3'd3: seg = 7'h30;
                3'd4: seg = 7'h19;
                3'd5: seg = 7'h12;
                3'd6: seg = 7'h02;
                3'd7: seg = 7'h78;
                default: seg = 7'h7F;
            endcase
        end
    end

endmodule
